vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Parametrised VGA raster timing generator that replaces the fixed 640x480 sync block.
- Derives a pixel-rate enable from the system clock.
- Generates horizontal and vertical pixel counters, and hsync/vsync with programmable polarity.
- Produces a correct active-area video_on plus line_start/frame_start strobes.
- Sits between the board clock and the pixel/object generators. Every downstream module uses pixel_tick as its clock enable.

Parameters:
CLK_DIV, 4, system clocks per pixel (>=1; 1 = pixel_tick every cycle)
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, hsync asserted level (0 = active-low)
VS_POL, 0, vsync asserted level (0 = active-low)
CW, 10, counter/output width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
en  input  1  run enable; low = synchronous clear and hold
pixel_tick  output  1  one-clk pulse every CLK_DIV clks while en=1
pixel_x  output  CW  horizontal count, 0..H_TOTAL-1
pixel_y  output  CW  vertical count, 0..V_TOTAL-1
hsync  output  1  horizontal sync, polarity HS_POL
vsync  output  1  vertical sync, polarity VS_POL
video_on  output  1  high only inside the active area
line_start  output  1  one-clk pulse at the start of each line
frame_start  output  1  one-clk pulse at the start of each frame

Behaviour:
Derived values:
- H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP (800 by default).
- V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP (525 by default).

Reset (rst=1, asynchronous):
- Divider = 0, pixel_x = 0, pixel_y = 0, pixel_tick = 0, video_on = 0, line_start = 0, frame_start = 0.
- hsync = ~HS_POL and vsync = ~VS_POL (deasserted).

en=0 (synchronous):
- Same values as reset on the next clk; held while en stays low.
- On the rising edge of en, the divider starts at 0. The first pixel_tick comes CLK_DIV clks later (1 clk later for CLK_DIV=1).

Divider:
- Counts 0..CLK_DIV-1 and wraps.
- pixel_tick is registered, high for the one clk after the divider reaches CLK_DIV-1.
- CLK_DIV=1: no divider register; pixel_tick = en registered.

Counters:
- Advance only on clk edges where pixel_tick=1.
- pixel_x increments and wraps from H_TOTAL-1 to 0.
- pixel_y increments only when pixel_x wraps, and wraps from V_TOTAL-1 to 0.
- Both use modulo arithmetic at width CW. There are no other update paths.

Sync, video and strobe outputs:
- Registered, decoded from the next counter values, so they are always aligned with pixel_x/pixel_y in the same clk. Zero skew between counters and sync.
- hsync asserted iff H_ACTIVE+H_FP <= pixel_x < H_ACTIVE+H_FP+H_SYNC (656..751 by default).
- vsync asserted iff V_ACTIVE+V_FP <= pixel_y < V_ACTIVE+V_FP+V_SYNC (490..491 by default).
- video_on = (pixel_x < H_ACTIVE) && (pixel_y < V_ACTIVE). Porches and sync are blanked.
- line_start: high for exactly one clk, the clk in which pixel_x changes to 0.
- frame_start: high for exactly one clk, the clk in which both counters change to (0,0). line_start is also high in that clk.

Boundary conditions:
- No strobe is issued coming out of reset or en=0; the first frame_start is at the first wrap.
- rst mid-frame: immediate return to reset values.
- en dropped mid-line: next clk clears, with no partial strobes.

Elaboration checks (simulation $error):
- CW too small for H_TOTAL-1 or V_TOTAL-1.
- CLK_DIV < 1.
- Any porch or sync parameter equal to 0.

Decomposition:
- Package vga_timing_pkg: default 640x480@60 constants (H_*, V_*, polarities), derived H_TOTAL/V_TOTAL, and an 800x600 constant set for alternate builds.
- One sub-module: pixel_tick_gen (CLK_DIV divider with en/rst, emits pixel_tick).
- Counters and decode stay in vga_timing_gen.

Test Plan:
- Defaults, rst then en=1 -> pixel_tick period 4 clks; pixel_x reaches 799 then 0; line_start pulses every 3200 clks; frame_start every 1,680,000 clks.
- Defaults -> hsync low exactly for pixel_x 656..751 (96 ticks); vsync low exactly for pixel_y 490..491 (1600 ticks); video_on high for 640x480 = 307200 ticks per frame.
- HS_POL=1, VS_POL=1, CLK_DIV=1 -> hsync high for 656..751; pixel_tick constant 1 after en; frame period 420000 clks.
- Small timing (H 8/2/2/2, V 4/1/1/1, CLK_DIV=2) -> H_TOTAL=14, V_TOTAL=7; frame_start every 196 clks, coincident with line_start; counters match a reference model every clk.
- Assert rst at pixel (300,200) -> same clk: all outputs at reset values; after release with en=1, counting resumes from (0,0) and there is no frame_start until the first wrap.
- Drop en at pixel (799,524) on the tick clk -> no frame_start; counters go to (0,0) and hold; re-raising en gives the first pixel_tick 4 clks later.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA raster constants: 640x480@60 defaults, an 800x600@60 alternate set,
// and the output bundle registered by the timing generator.
package vga_timing_pkg;

  function automatic int unsigned span_total(input int unsigned active, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  // 640x480@60, 25.175 MHz pixel clock
  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;
  localparam bit          VGA_HS_POL   = 1'b0;
  localparam bit          VGA_VS_POL   = 1'b0;
  localparam int unsigned VGA_CW       = 10;
  localparam int unsigned VGA_H_TOTAL  = span_total(VGA_H_ACTIVE, VGA_H_FP, VGA_H_SYNC, VGA_H_BP);
  localparam int unsigned VGA_V_TOTAL  = span_total(VGA_V_ACTIVE, VGA_V_FP, VGA_V_SYNC, VGA_V_BP);

  // 800x600@60, 40 MHz pixel clock, positive syncs
  localparam int unsigned SVGA_H_ACTIVE = 800;
  localparam int unsigned SVGA_H_FP     = 40;
  localparam int unsigned SVGA_H_SYNC   = 128;
  localparam int unsigned SVGA_H_BP     = 88;
  localparam int unsigned SVGA_V_ACTIVE = 600;
  localparam int unsigned SVGA_V_FP     = 1;
  localparam int unsigned SVGA_V_SYNC   = 4;
  localparam int unsigned SVGA_V_BP     = 23;
  localparam bit          SVGA_HS_POL   = 1'b1;
  localparam bit          SVGA_VS_POL   = 1'b1;
  localparam int unsigned SVGA_CW       = 11;
  localparam int unsigned SVGA_H_TOTAL  = span_total(SVGA_H_ACTIVE, SVGA_H_FP, SVGA_H_SYNC, SVGA_H_BP);
  localparam int unsigned SVGA_V_TOTAL  = span_total(SVGA_V_ACTIVE, SVGA_V_FP, SVGA_V_SYNC, SVGA_V_BP);

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic video_on;
    logic line_start;
    logic frame_start;
  } vga_ctrl_t;

endpackage

// File: rtl/vga_timing_gen_pixel_tick.sv
// Pixel-rate enable: one-clk pulse every CLK_DIV system clocks while en is high.
module pixel_tick_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic pixel_tick
);

  logic tick_q, tick_d;

  generate
    if (CLK_DIV <= 1) begin : g_nodiv
      always_comb tick_d = en;
    end else begin : g_div
      localparam int unsigned DW = $clog2(CLK_DIV);
      localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

      logic [DW-1:0] div_q, div_d;

      // Dropping en restarts the divider so the first tick lands CLK_DIV clks after en rises
      always_comb begin
        div_d  = '0;
        tick_d = 1'b0;
        if (en) begin
          tick_d = (div_q == DIV_LAST);
          div_d  = tick_d ? '0 : div_q + DW'(1);
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) div_q <= '0;
        else     div_q <= div_d;
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tick_q <= 1'b0;
    else     tick_q <= tick_d;
  end

  assign pixel_tick = tick_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing: pixel counters plus sync, video_on and line/frame
// strobes, all registered from the next counter values so they share one clk.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP,
  parameter bit          HS_POL   = VGA_HS_POL,
  parameter bit          VS_POL   = VGA_VS_POL,
  parameter int unsigned CW       = VGA_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic          pixel_tick,
  output logic [CW-1:0] pixel_x,
  output logic [CW-1:0] pixel_y,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic          line_start,
  output logic          frame_start
);

  localparam int unsigned H_TOTAL = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  generate
    if (((H_TOTAL - 1) >> CW) != 0 || ((V_TOTAL - 1) >> CW) != 0) begin : g_bad_cw
      $error("vga_timing_gen: CW=%0d cannot hold H_TOTAL-1=%0d / V_TOTAL-1=%0d",
             CW, H_TOTAL - 1, V_TOTAL - 1);
    end
    if (CLK_DIV < 1) begin : g_bad_div
      $error("vga_timing_gen: CLK_DIV must be >= 1");
    end
    if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_porch
      $error("vga_timing_gen: porch and sync widths must be non-zero");
    end
  endgenerate

  localparam logic [CW-1:0] X_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] Y_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] X_ACTIVE = CW'(H_ACTIVE);
  localparam logic [CW-1:0] Y_ACTIVE = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

  localparam vga_ctrl_t CTRL_IDLE = '{hsync: ~HS_POL, vsync: ~VS_POL, video_on: 1'b0,
                                      line_start: 1'b0, frame_start: 1'b0};

  logic          tick;
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  vga_ctrl_t     ctrl_q, ctrl_d;
  logic          x_wrap, y_wrap;

  pixel_tick_gen #(.CLK_DIV(CLK_DIV)) u_pixel_tick (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .pixel_tick (tick)
  );

  assign x_wrap = (x_q == X_LAST);
  assign y_wrap = (y_q == Y_LAST);

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (!en) begin
      x_d = '0;
      y_d = '0;
    end else if (tick) begin
      x_d = x_wrap ? '0 : x_q + CW'(1);
      if (x_wrap) y_d = y_wrap ? '0 : y_q + CW'(1);
    end
  end

  // Decode from x_d/y_d so the registered outputs line up with the counters
  always_comb begin
    ctrl_d = CTRL_IDLE;
    if (en) begin
      ctrl_d.hsync       = (x_d >= HS_START && x_d < HS_END) ? HS_POL : ~HS_POL;
      ctrl_d.vsync       = (y_d >= VS_START && y_d < VS_END) ? VS_POL : ~VS_POL;
      ctrl_d.video_on    = (x_d < X_ACTIVE) && (y_d < Y_ACTIVE);
      ctrl_d.line_start  = tick && x_wrap;
      ctrl_d.frame_start = tick && x_wrap && y_wrap;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q    <= '0;
      y_q    <= '0;
      ctrl_q <= CTRL_IDLE;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      ctrl_q <= ctrl_d;
    end
  end

  assign pixel_tick  = tick;
  assign pixel_x     = x_q;
  assign pixel_y     = y_q;
  assign hsync       = ctrl_q.hsync;
  assign vsync       = ctrl_q.vsync;
  assign video_on    = ctrl_q.video_on;
  assign line_start  = ctrl_q.line_start;
  assign frame_start = ctrl_q.frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a small raster (14x7, CLK_DIV=2) against a closed-form
// model indexed by the number of enabled clks since the last clear.
module tb_vga_timing_gen;

  localparam int DIV = 2;
  localparam int HA = 8, HF = 2, HS = 2, HB = 2;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int CW = 4;
  localparam bit HP = 1'b0;
  localparam bit VP = 1'b1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b0;
  logic          pixel_tick;
  logic [CW-1:0] pixel_x, pixel_y;
  logic          hsync, vsync, video_on, line_start, frame_start;

  vga_timing_gen #(
    .CLK_DIV(DIV), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(HP), .VS_POL(VP), .CW(CW)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .pixel_tick(pixel_tick),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .hsync(hsync), .vsync(vsync),
    .video_on(video_on), .line_start(line_start), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          tick;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          hs;
    logic          vs;
    logic          von;
    logic          ls;
    logic          fs;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp   = 0;
  int   n_bad   = 0;
  int   c       = 0;   // enabled clks since last clear
  int   cyc     = 0;
  int   last_fs = -1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t c=%0d)", tag, got, want, $time, c);
    end
  endtask

  // n ticks consumed after clk cc: counters advance on clks DIV+1, 2*DIV+1, ...
  function automatic exp_t model(input int cc);
    exp_t e;
    int n, px, py;
    e = '{tick: 1'b0, x: '0, y: '0, hs: ~HP, vs: ~VP, von: 1'b0, ls: 1'b0, fs: 1'b0};
    if (cc > 0) begin
      n  = (cc - 1) / DIV;
      px = n % HT;
      py = (n / HT) % VT;
      e.tick = (cc % DIV == 0);
      e.x    = CW'(px);
      e.y    = CW'(py);
      e.hs   = (px >= HA + HF && px < HA + HF + HS) ? HP : ~HP;
      e.vs   = (py >= VA + VF && py < VA + VF + VS) ? VP : ~VP;
      e.von  = (px < HA) && (py < VA);
      e.ls   = (cc > 1) && ((cc - 1) % DIV == 0) && (px == 0);
      e.fs   = e.ls && (py == 0);
    end
    return e;
  endfunction

  task automatic compare_out();
    exp_t e;
    if (exp_q.size() == 0) begin
      check_val("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    check_val("pixel_tick",  32'(pixel_tick),  32'(e.tick));
    check_val("pixel_x",     32'(pixel_x),     32'(e.x));
    check_val("pixel_y",     32'(pixel_y),     32'(e.y));
    check_val("hsync",       32'(hsync),       32'(e.hs));
    check_val("vsync",       32'(vsync),       32'(e.vs));
    check_val("video_on",    32'(video_on),    32'(e.von));
    check_val("line_start",  32'(line_start),  32'(e.ls));
    check_val("frame_start", 32'(frame_start), 32'(e.fs));
    if (c == 0) last_fs = -1;
    if (frame_start === 1'b1) begin
      if (last_fs >= 0) check_val("frame_period", 32'(cyc - last_fs), 32'(HT * VT * DIV));
      last_fs = cyc;
    end
  endtask

  task automatic step(input logic en_v);
    en = en_v;
    @(posedge clk);
    cyc++;
    c = (en_v && !rst) ? c + 1 : 0;
    exp_q.push_back(model(c));
    @(negedge clk);
    compare_out();
  endtask

  // Step with en=1 until the model sits at (px,py), optionally on a tick clk
  task automatic run_to(input int px, input int py, input bit need_tick, input string tag);
    exp_t m;
    for (int i = 0; i < 4 * HT * VT * DIV; i++) begin
      m = model(c);
      if (c > 0 && int'(m.x) == px && int'(m.y) == py && (!need_tick || m.tick)) return;
      step(1'b1);
    end
    check_val({"timeout_", tag}, 32'd0, 32'd1);
  endtask

  initial begin
    // Reset held with en low
    for (int i = 0; i < 3; i++) step(1'b0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b0);

    // Free run for 2.5 frames: tick every DIV clks, strobes at wraps only
    for (int i = 0; i < (5 * HT * VT * DIV) / 2; i++) step(1'b1);

    // Asynchronous reset mid-frame, away from the clock edge
    run_to(5, 2, 1'b0, "rst_point");
    #3;
    rst = 1'b1;
    #1;
    c = 0;
    exp_q.push_back(model(0));
    compare_out();
    step(1'b1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < HT * VT * DIV + 20; i++) step(1'b1);

    // en dropped mid-line on a non-tick clk, held, then restarted
    run_to(4, 1, 1'b0, "mid_line");
    for (int i = 0; i < 4; i++) step(1'b0);
    for (int i = 0; i < 40; i++) step(1'b1);

    // en dropped on the tick clk at the last pixel of the frame: no frame_start
    run_to(HT - 1, VT - 1, 1'b1, "last_pixel");
    for (int i = 0; i < 3; i++) step(1'b0);
    for (int i = 0; i < HT * VT * DIV + 10; i++) step(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
